// File: rtl/shiftreg_univ.sv
`default_nettype none
// ============================================================================
// Module      : shiftreg_univ
// Description : WIDTH-bit universal shift register (hold, shift, rotate,
//               load, clear) with a frame counter flagging every WIDTH shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module shiftreg_univ #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic                     sin_l,
    input  logic                     sin_r,
    input  logic [WIDTH-1:0]         pdata,
    output logic [WIDTH-1:0]         q,
    output logic                     sout_l,
    output logic                     sout_r,
    output logic [$clog2(WIDTH)-1:0] shift_cnt,
    output logic                     frame_done
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_SHL  = 3'b001;
    localparam logic [2:0] c_MODE_LSR  = 3'b010;
    localparam logic [2:0] c_MODE_ROL  = 3'b011;
    localparam logic [2:0] c_MODE_ROR  = 3'b100;
    localparam logic [2:0] c_MODE_LOAD = 3'b101;
    localparam logic [2:0] c_MODE_ASR  = 3'b110;
    localparam logic [2:0] c_MODE_CLR  = 3'b111;

    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_fd;
    logic               w_fd_nxt;
    logic               w_op_shift;
    logic               w_op_restart;

    always_comb begin
        w_q_nxt      = r_q;
        w_op_shift   = 1'b0;
        w_op_restart = 1'b0;
        if (en) begin
            case (mode)
                c_MODE_HOLD: w_q_nxt = r_q;
                c_MODE_SHL: begin
                    w_q_nxt    = {r_q[WIDTH-2:0], sin_l};
                    w_op_shift = 1'b1;
                end
                c_MODE_LSR: begin
                    w_q_nxt    = {sin_r, r_q[WIDTH-1:1]};
                    w_op_shift = 1'b1;
                end
                c_MODE_ROL: begin
                    w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_op_shift = 1'b1;
                end
                c_MODE_ROR: begin
                    w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
                    w_op_shift = 1'b1;
                end
                c_MODE_LOAD: begin
                    w_q_nxt      = pdata;
                    w_op_restart = 1'b1;
                end
                c_MODE_ASR: begin
                    w_q_nxt    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                    w_op_shift = 1'b1;
                end
                c_MODE_CLR: begin
                    w_q_nxt      = '0;
                    w_op_restart = 1'b1;
                end
                default: w_q_nxt = r_q;
            endcase
        end
    end

    // Load and clear open a fresh frame; only shift ops advance the count.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_fd_nxt  = 1'b0;
        if (w_op_restart) begin
            w_cnt_nxt = '0;
        end else if (w_op_shift) begin
            if (r_cnt == c_CNT_LAST) begin
                w_cnt_nxt = '0;
                w_fd_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= RESET_VAL;
            r_cnt <= '0;
            r_fd  <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_cnt <= w_cnt_nxt;
            r_fd  <= w_fd_nxt;
        end
    end

    assign q          = r_q;
    assign sout_l     = r_q[WIDTH-1];
    assign sout_r     = r_q[0];
    assign shift_cnt  = r_cnt;
    assign frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_univ.sv
`default_nettype none
// ============================================================================
// Module      : tb_shiftreg_univ
// Description : Self-checking bench for shiftreg_univ at widths 8, 3 and 32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shiftreg_univ;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic        sin_l = 1'b0;
    logic        sin_r = 1'b0;
    logic [31:0] pdata = '0;
    bit          chk_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  q8;
    logic [2:0]  cnt8;
    logic        sl8, sr8, fd8;
    logic [2:0]  q3;
    logic [1:0]  cnt3;
    logic        sl3, sr3, fd3;
    logic [31:0] q32;
    logic [4:0]  cnt32;
    logic        sl32, sr32, fd32;

    always #5 clk = ~clk;

    shiftreg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
        .pdata(pdata[7:0]), .q(q8), .sout_l(sl8), .sout_r(sr8),
        .shift_cnt(cnt8), .frame_done(fd8));

    shiftreg_univ #(.WIDTH(3), .RESET_VAL(3'b101)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
        .pdata(pdata[2:0]), .q(q3), .sout_l(sl3), .sout_r(sr3),
        .shift_cnt(cnt3), .frame_done(fd3));

    shiftreg_univ #(.WIDTH(32), .RESET_VAL(32'hDEADBEEF)) u_dut32 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
        .pdata(pdata), .q(q32), .sout_l(sl32), .sout_r(sr32),
        .shift_cnt(cnt32), .frame_done(fd32));

    // Reference model: index 0 -> width 8, 1 -> width 3, 2 -> width 32
    int          c_w  [3] = '{8, 3, 32};
    logic [31:0] c_rv [3] = '{32'hA5, 32'h5, 32'hDEADBEEF};
    logic [31:0] m_q  [3];
    int          m_n  [3];
    bit          m_fd [3];

    function automatic logic [31:0] f_next(input logic [31:0] qv, input int w,
                                           input logic [2:0] m, input logic sl,
                                           input logic sr, input logic [31:0] pd);
        logic [63:0] x, mask, top;
        logic        msb, lsb;
        x    = {32'b0, qv};
        mask = (64'd1 << w) - 64'd1;
        top  = 64'd1 << (w - 1);
        msb  = qv[w-1];
        lsb  = qv[0];
        case (m)
            3'd1: x = (x << 1) | {63'b0, sl};
            3'd2: x = (x >> 1) | (sr ? top : 64'd0);
            3'd3: x = (x << 1) | {63'b0, msb};
            3'd4: x = (x >> 1) | (lsb ? top : 64'd0);
            3'd5: x = {32'b0, pd};
            3'd6: x = (x >> 1) | (msb ? top : 64'd0);
            3'd7: x = 64'd0;
            default: ;
        endcase
        return 32'(x & mask);
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            logic [2:0] me;
            bit         sh, rs;
            int         nn;
            if (reset) begin
                m_q[i]  <= c_rv[i];
                m_n[i]  <= 0;
                m_fd[i] <= 1'b0;
            end else begin
                me = en ? mode : 3'd0;
                sh = (me == 3'd1) || (me == 3'd2) || (me == 3'd3) ||
                     (me == 3'd4) || (me == 3'd6);
                rs = (me == 3'd5) || (me == 3'd7);
                nn = rs ? 0 : (sh ? m_n[i] + 1 : m_n[i]);
                m_q[i]  <= f_next(m_q[i], c_w[i], me, sin_l, sin_r, pdata);
                m_n[i]  <= nn;
                m_fd[i] <= sh && (nn % c_w[i] == 0);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("q8", {24'b0, q8}, m_q[0]);
            chk("cnt8", {29'b0, cnt8}, 32'(m_n[0] % 8));
            chk("fd8", {31'b0, fd8}, {31'b0, m_fd[0]});
            chk("soutl8", {31'b0, sl8}, {31'b0, m_q[0][7]});
            chk("soutr8", {31'b0, sr8}, {31'b0, m_q[0][0]});
            chk("q3", {29'b0, q3}, m_q[1]);
            chk("cnt3", {30'b0, cnt3}, 32'(m_n[1] % 3));
            chk("fd3", {31'b0, fd3}, {31'b0, m_fd[1]});
            chk("soutl3", {31'b0, sl3}, {31'b0, m_q[1][2]});
            chk("q32", q32, m_q[2]);
            chk("cnt32", {27'b0, cnt32}, 32'(m_n[2] % 32));
            chk("fd32", {31'b0, fd32}, {31'b0, m_fd[2]});
            chk("soutr32", {31'b0, sr32}, {31'b0, m_q[2][0]});
        end
    end

    task automatic do_op(input logic e, input logic [2:0] m, input logic sl,
                         input logic sr, input logic [31:0] pd);
        en    = e;
        mode  = m;
        sin_l = sl;
        sin_r = sr;
        pdata = pd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  pat;
        logic [31:0] hist;
        int          p8, p3, p32;
        logic        s;

        #2 reset = 1'b1;
        #20;
        chk("rst_q8", {24'b0, q8}, 32'hA5);
        chk("rst_cnt8", {29'b0, cnt8}, 32'd0);
        chk("rst_fd8", {31'b0, fd8}, 32'd0);
        reset  = 1'b0;
        chk_on = 1'b1;

        // serial-to-parallel
        pat = 8'b10110010;
        for (int i = 7; i >= 0; i--) do_op(1'b1, 3'd1, pat[i], 1'b0, 32'd0);
        chk("s2p_q", {24'b0, q8}, 32'hB2);
        chk("s2p_fd", {31'b0, fd8}, 32'd1);
        chk("s2p_cnt", {29'b0, cnt8}, 32'd0);
        do_op(1'b1, 3'd1, 1'b0, 1'b0, 32'd0);
        chk("s2p9_cnt", {29'b0, cnt8}, 32'd1);
        chk("s2p9_fd", {31'b0, fd8}, 32'd0);

        // rotate / arithmetic
        do_op(1'b1, 3'd5, 1'b0, 1'b0, 32'h81);
        chk("ld81", {24'b0, q8}, 32'h81);
        do_op(1'b1, 3'd3, 1'b0, 1'b0, 32'd0);
        chk("rol", {24'b0, q8}, 32'h03);
        do_op(1'b1, 3'd4, 1'b0, 1'b0, 32'd0);
        do_op(1'b1, 3'd4, 1'b0, 1'b0, 32'd0);
        chk("ror2", {24'b0, q8}, 32'hC0);
        do_op(1'b1, 3'd5, 1'b0, 1'b0, 32'h90);
        do_op(1'b1, 3'd6, 1'b0, 1'b0, 32'd0);
        chk("asr", {24'b0, q8}, 32'hC8);
        do_op(1'b1, 3'd2, 1'b0, 1'b0, 32'd0);
        chk("lsr", {24'b0, q8}, 32'h64);

        // enable / hold mid-frame
        do_op(1'b1, 3'd7, 1'b0, 1'b0, 32'd0);
        repeat (5) do_op(1'b1, 3'd1, 1'b1, 1'b0, 32'd0);
        repeat (3) do_op(1'b0, 3'd1, 1'b0, 1'b0, 32'd0);
        chk("hold_q", {24'b0, q8}, 32'h1F);
        chk("hold_cnt", {29'b0, cnt8}, 32'd5);
        repeat (2) do_op(1'b1, 3'd1, 1'b0, 1'b0, 32'd0);
        chk("resume_fd0", {31'b0, fd8}, 32'd0);
        do_op(1'b1, 3'd1, 1'b0, 1'b0, 32'd0);
        chk("resume_fd1", {31'b0, fd8}, 32'd1);
        chk("resume_q", {24'b0, q8}, 32'hF8);

        // load / clear mid-frame
        repeat (6) do_op(1'b1, 3'd1, 1'b1, 1'b0, 32'd0);
        chk("mid_cnt", {29'b0, cnt8}, 32'd6);
        do_op(1'b1, 3'd5, 1'b0, 1'b0, 32'h3C);
        chk("ld3c_q", {24'b0, q8}, 32'h3C);
        chk("ld3c_cnt", {29'b0, cnt8}, 32'd0);
        chk("ld3c_fd", {31'b0, fd8}, 32'd0);
        do_op(1'b1, 3'd7, 1'b0, 1'b0, 32'd0);
        chk("clr_q", {24'b0, q8}, 32'h0);

        // asynchronous reset mid-frame, mid-cycle
        repeat (4) do_op(1'b1, 3'd1, 1'b1, 1'b0, 32'd0);
        en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_q8", {24'b0, q8}, 32'hA5);
        chk("arst_cnt8", {29'b0, cnt8}, 32'd0);
        chk("arst_fd8", {31'b0, fd8}, 32'd0);
        chk("arst_q3", {29'b0, q3}, 32'h5);
        chk("arst_q32", q32, 32'hDEADBEEF);
        #1 reset = 1'b0;
        repeat (7) do_op(1'b1, 3'd1, 1'b0, 1'b0, 32'd0);
        chk("post_rst_fd0", {31'b0, fd8}, 32'd0);
        do_op(1'b1, 3'd1, 1'b0, 1'b0, 32'd0);
        chk("post_rst_fd1", {31'b0, fd8}, 32'd1);

        // width scaling: long shift-left run
        do_op(1'b1, 3'd7, 1'b0, 1'b0, 32'd0);
        hist = '0;
        p8 = 0; p3 = 0; p32 = 0;
        repeat (96) begin
            s = 1'($urandom);
            do_op(1'b1, 3'd1, s, 1'b0, 32'd0);
            hist = {hist[30:0], s};
            if (fd8)  p8++;
            if (fd3)  p3++;
            if (fd32) p32++;
        end
        chk("run_q32", q32, hist);
        chk("run_q3", {29'b0, q3}, {29'b0, hist[2:0]});
        chk("run_q8", {24'b0, q8}, {24'b0, hist[7:0]});
        chk("pulses8", 32'(p8), 32'd12);
        chk("pulses3", 32'(p3), 32'd32);
        chk("pulses32", 32'(p32), 32'd3);

        // randomized operation mix
        repeat (600) begin
            do_op(($urandom % 8) != 0, 3'($urandom), 1'($urandom), 1'($urandom), $urandom);
            if ($urandom % 150 == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shiftreg_univ.md
# shiftreg_univ

Parametrised universal shift register, successor to the fixed 3-bit serial-in shift register. Supports hold, logical/arithmetic shift, rotate, parallel load and synchronous clear on a WIDTH-bit register. A frame counter flags every WIDTH completed shifts, so serial-to-parallel and parallel-to-serial datapaths can use the block without an external bit counter.

## Interface

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; when 0 the register and counter hold.
- mode  input  3  operation select, sampled when en=1.
- sin_l  input  1  serial input entering bit 0 on shift left.
- sin_r  input  1  serial input entering bit WIDTH-1 on logical shift right.
- pdata  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- shift_cnt  output  $clog2(WIDTH)  number of shifts completed in the current frame, 0..WIDTH-1.
- frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame.

## Operation

- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - q = RESET_VAL
  - shift_cnt = 0
  - frame_done = 0
  - sout_l/sout_r follow q
- Reset asserted mid-frame discards the frame; it does not generate a frame_done pulse.
- Mode encoding (applies only when en=1; en=0 behaves as 000):
  - 000 hold: q unchanged.
  - 001 shift left: q <= {q[WIDTH-2:0], sin_l}.
  - 010 logical shift right: q <= {sin_r, q[WIDTH-1:1]}.
  - 011 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 101 parallel load: q <= pdata.
  - 110 arithmetic shift right: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
  - 111 clear: q <= 0.
- Shift ops are modes 001, 010, 011, 100 and 110. Each enabled shift op increments the frame count.
- Frame counter:
  - On a shift op with shift_cnt = WIDTH-1, shift_cnt wraps to 0 and frame_done is 1 for the following cycle.
  - On any other shift op, shift_cnt increments and frame_done is 0.
  - Modes 101 and 111 force shift_cnt to 0 and frame_done to 0; they start a new frame.
  - Hold or en=0: shift_cnt holds and frame_done is 0.
- Mixed shift directions within one frame are counted identically; direction does not affect the count.
- No illegal modes; all 8 encodings are defined.

## Timing

- All updates happen on the rising edge of clk. Latency is one cycle from the mode/data sample to the new q.
- sout_l/sout_r reflect the new q in the same cycle q changes; there is no extra register stage.
- frame_done is registered:
  - high exactly one cycle, in the cycle after the edge that completed the WIDTH-th shift;
  - it coincides with shift_cnt = 0.
- Back-to-back frames: continuous shifting yields one frame_done pulse every WIDTH cycles.
- Inputs sin_l, sin_r and pdata are sampled only on the edge where they are used.
- Reset release: the first edge with reset low may perform an operation.

## Test plan

- Reset: assert reset asynchronously mid-cycle with RESET_VAL=8'hA5, WIDTH=8 -> q=8'hA5, shift_cnt=0, frame_done=0 immediately, before the next clk edge.
- Serial-to-parallel:
  - stimulus: mode=001, en=1; drive sin_l = 1,0,1,1,0,0,1,0 on 8 consecutive edges;
  - response: q=8'b10110010 after the 8th edge, frame_done=1 for exactly that next cycle, shift_cnt=0;
  - a 9th shift -> shift_cnt=1, frame_done=0.
- Rotate and arithmetic shift:
  - load pdata=8'h81 -> q=8'h81;
  - rotate left -> 8'h03; rotate right twice -> 8'hC0;
  - load 8'h90, arithmetic shift right -> 8'hC8;
  - logical shift right with sin_r=0 -> 8'h64.
- Enable/hold:
  - stimulus: mid-frame at shift_cnt=5, deassert en for 3 cycles with mode=001;
  - response: q and shift_cnt unchanged;
  - resume: frame_done fires after 3 further shifts.
- Load/clear mid-frame: at shift_cnt=6, apply mode=101 with pdata=8'h3C -> q=8'h3C, shift_cnt=0, and no frame_done pulse; then mode=111 -> q=0.
- Width scaling: instantiate WIDTH=3 and WIDTH=32 -> shift-left sequences produce correct q, and frame_done pulses every 3 and 32 shifts respectively.
